// File: rtl/trig_alignment_pkg.sv
// trig_alignment_pkg: shared state encoding, default timeout and width helpers for the alignment supervisor
// Contents:
//   state_e         - supervisor FSM states (IDLE=0, SCAN=1, RESET=2, WAIT=3)
//   DEFAULT_TIMEOUT - suggested per-attempt wait budget in clocks
//   idx_width()     - bits needed to index n items (never less than 1)
//   retry_width()   - bits needed to hold a retry count of 0..max_retries
package trig_alignment_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_RESET = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;
  localparam logic [15:0] DEFAULT_TIMEOUT = 16'd1000;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int retry_width(input int max_retries);
    return idx_width(max_retries + 1);
  endfunction
endpackage

// File: rtl/vfat_retry_counter.sv
// vfat_retry_counter: per-VFAT retry count with sticky failed flag
// Ports:
//   clock_i, reset_n_i - clock, async active-low reset
//   inc_i              - one failed attempt (timeout) for this VFAT
//   clr_i              - attempt succeeded, restart the retry count
//   gclr_i             - global clear of count and failed flag, wins over inc_i
//   exhausted_o        - the next inc_i uses up the last retry
//   failed_o           - sticky retry-exhausted flag
module vfat_retry_counter
  import trig_alignment_pkg::*;
#(
  parameter int MAX_RETRIES = 7
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic inc_i,
  input  logic clr_i,
  input  logic gclr_i,
  output logic exhausted_o,
  output logic failed_o
);
  localparam int RW = retry_width(MAX_RETRIES);
  logic [RW-1:0] cnt_q, cnt_d;
  logic          failed_q, failed_d;
  // The count never reaches MAX_RETRIES: the final failure sets the flag and restarts at 0
  assign exhausted_o = cnt_q == RW'(MAX_RETRIES - 1);
  assign failed_o    = failed_q;
  always_comb begin
    cnt_d    = (gclr_i || clr_i || (inc_i && exhausted_o)) ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
    failed_d = !gclr_i && (failed_q || (inc_i && exhausted_o));
  end
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q    <= '0;
      failed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      failed_q <= failed_d;
    end
  end
endmodule

// File: rtl/trig_alignment_supervisor.sv
// trig_alignment_supervisor: round-robin supervisor issuing timed resets to misaligned S-bit frame aligners
// Ports:
//   clock_i, reset_n_i  - fabric clock, async active-low reset
//   enable_i            - run enable (level); low returns to IDLE keeping failed/retry/count state
//   timeout_cycles_i    - wait budget per attempt, 0 behaves as 1
//   clear_failed_i      - pulse clearing all failed flags and retry counts
//   vfat_mask_i         - 1 = VFAT ignored, never reset
//   sot_is_aligned_i    - per-aligner aligned flag
//   sot_unstable_i      - per-aligner sticky unstable flag
//   aligner_reset_o     - registered per-aligner reset, at most one bit high
//   failed_o            - sticky per-VFAT retry-exhausted flags
//   all_aligned_o       - registered aggregate health (aligned, masked or failed everywhere) and enable
//   busy_o              - FSM in RESET or WAIT
//   active_vfat_o       - current scan index
//   realign_cnt_o       - saturating count of reset pulses issued
module trig_alignment_supervisor
  import trig_alignment_pkg::*;
#(
  parameter int NVFATS       = 24,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_RETRIES  = 7
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         enable_i,
  input  logic [15:0]                  timeout_cycles_i,
  input  logic                         clear_failed_i,
  input  logic [NVFATS-1:0]            vfat_mask_i,
  input  logic [NVFATS-1:0]            sot_is_aligned_i,
  input  logic [NVFATS-1:0]            sot_unstable_i,
  output logic [NVFATS-1:0]            aligner_reset_o,
  output logic [NVFATS-1:0]            failed_o,
  output logic                         all_aligned_o,
  output logic                         busy_o,
  output logic [idx_width(NVFATS)-1:0] active_vfat_o,
  output logic [15:0]                  realign_cnt_o
);
  localparam int IW = idx_width(NVFATS);
  localparam int PW = idx_width(RESET_CYCLES);
  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, idx_nx;
  logic [PW-1:0]     pulse_q, pulse_d;
  logic [15:0]       timer_q, timer_d, tmo, realign_q, realign_d;
  logic [NVFATS-1:0] ar_q, ar_d, sel, exh, inc, clr;
  logic              all_q, all_d, need, ok, expire, abort, succ, tout;
  assign sel    = NVFATS'(1) << idx_q;
  assign idx_nx = (idx_q == IW'(NVFATS - 1)) ? '0 : idx_q + 1'b1;
  assign tmo    = (timeout_cycles_i == 16'd0) ? 16'd1 : timeout_cycles_i;
  assign need   = !vfat_mask_i[idx_q] && !failed_o[idx_q] && (sot_unstable_i[idx_q] || !sot_is_aligned_i[idx_q]);
  assign ok     = sot_is_aligned_i[idx_q] && !sot_unstable_i[idx_q];
  // Widened so a 0xFFFF budget still terminates
  assign expire = ({1'b0, timer_q} + 17'd1) >= {1'b0, tmo};
  assign abort  = vfat_mask_i[idx_q] && (state_q == ST_RESET || state_q == ST_WAIT);
  assign inc    = tout ? sel : '0;
  assign clr    = succ ? sel : '0;
  for (genvar g = 0; g < NVFATS; g++) begin : g_retry
    vfat_retry_counter #(.MAX_RETRIES(MAX_RETRIES)) u_retry (
      .clock_i,
      .reset_n_i,
      .inc_i      (inc[g]),
      .clr_i      (clr[g]),
      .gclr_i     (clear_failed_i),
      .exhausted_o(exh[g]),
      .failed_o   (failed_o[g])
    );
  end
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pulse_q   <= '0;
      timer_q   <= '0;
      ar_q      <= '0;
      realign_q <= '0;
      all_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pulse_q   <= pulse_d;
      timer_q   <= timer_d;
      ar_q      <= ar_d;
      realign_q <= realign_d;
      all_q     <= all_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pulse_d = '0;
    timer_d = '0;
    succ    = 1'b0;
    tout    = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (abort) begin
      state_d = ST_SCAN;
      idx_d   = idx_nx;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_SCAN;
        ST_SCAN:  if (need) state_d = ST_RESET; else idx_d = idx_nx;
        ST_RESET: if (pulse_q == PW'(RESET_CYCLES - 1)) state_d = ST_WAIT; else pulse_d = pulse_q + 1'b1;
        ST_WAIT: begin
          if (ok) begin
            succ    = 1'b1;
            state_d = ST_SCAN;
            idx_d   = idx_nx;
          end else if (expire) begin
            tout    = 1'b1;
            state_d = exh[idx_q] ? ST_SCAN : ST_RESET;
            idx_d   = exh[idx_q] ? idx_nx : idx_q;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  // Outputs are registered from next-state so the reset rises the clock after the detecting SCAN cycle
  always_comb begin
    ar_d      = (state_d == ST_RESET) ? NVFATS'(1) << idx_d : '0;
    realign_d = (state_d == ST_RESET && state_q != ST_RESET && realign_q != 16'hFFFF) ? realign_q + 1'b1 : realign_q;
    all_d     = enable_i && &(sot_is_aligned_i | vfat_mask_i | failed_o);
  end
  assign aligner_reset_o = ar_q;
  assign all_aligned_o   = all_q;
  assign busy_o          = state_q == ST_RESET || state_q == ST_WAIT;
  assign active_vfat_o   = idx_q;
  assign realign_cnt_o   = realign_q;
endmodule
